// File: rtl/cdb_arbiter_pkg.sv
// Shared constants and helpers for the common-data-bus arbiter.
package cdb_arbiter_pkg;

  localparam int CDB_TAG_W  = 4;
  localparam int CDB_DATA_W = 32;
  localparam logic [CDB_TAG_W-1:0] TAG_NONE = '0;

  // Round-robin successor of the winning source index.
  function automatic int rr_next(input int w, input int n);
    return (w == n - 1) ? 0 : w + 1;
  endfunction

endpackage

// File: rtl/cdb_arbiter_rr_pick.sv
// Combinational round-robin picker: the lowest eligible index at or after rr_ptr,
// wrapping, using a double-width mask-and-priority search.
module cdb_arbiter_rr_pick #(
  parameter int NUM_SRC = 4,
  localparam int PTR_W  = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] eligible,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic               any_grant,
  output logic [NUM_SRC-1:0] grant
);

  logic [NUM_SRC-1:0]   upper_mask;
  logic [2*NUM_SRC-1:0] dbl_req;
  logic [2*NUM_SRC-1:0] dbl_grant;

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      upper_mask[i] = (i >= int'(rr_ptr));
    end
    // Low half holds requests at/after the pointer, so they take priority over the wrapped copy.
    dbl_req   = {eligible, eligible & upper_mask};
    dbl_grant = dbl_req & ((~dbl_req) + (2*NUM_SRC)'(1));
    grant     = dbl_grant[NUM_SRC-1:0] | dbl_grant[2*NUM_SRC-1:NUM_SRC];
    any_grant = |eligible;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: grants one functional-unit result per cycle in round-robin
// order, registers the broadcast and pulses a one-hot acknowledge to the winner.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int TAG_W   = CDB_TAG_W,
  parameter int DATA_W  = CDB_DATA_W
) (
  input  logic                      clk,
  input  logic                      nRST,
  input  logic [NUM_SRC-1:0]        reqValid,
  input  logic [NUM_SRC*TAG_W-1:0]  reqTag,
  input  logic [NUM_SRC*DATA_W-1:0] reqData,
  output logic [NUM_SRC-1:0]        resultAC,
  output logic                      cdbValid,
  output logic [TAG_W-1:0]          cdbTag,
  output logic [DATA_W-1:0]         cdbData
);

  localparam int PTR_W = $clog2(NUM_SRC);

  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [NUM_SRC-1:0] ack_q, ack_d;
  logic               valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [DATA_W-1:0]  data_q, data_d;

  logic [NUM_SRC-1:0] eligible;
  logic [NUM_SRC-1:0] grant;
  logic               any_grant;
  logic [TAG_W-1:0]   mux_tag;
  logic [DATA_W-1:0]  mux_data;
  logic [PTR_W-1:0]   win_idx;

  // A source still sees its own request high during its ack cycle; mask it out.
  assign eligible = reqValid & ~ack_q;

  cdb_arbiter_rr_pick #(.NUM_SRC(NUM_SRC)) u_rr_pick (
    .eligible  (eligible),
    .rr_ptr    (rr_ptr_q),
    .any_grant (any_grant),
    .grant     (grant)
  );

  always_comb begin
    mux_tag  = '0;
    mux_data = '0;
    win_idx  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      mux_tag  = mux_tag  | (reqTag[i*TAG_W +: TAG_W]    & {TAG_W{grant[i]}});
      mux_data = mux_data | (reqData[i*DATA_W +: DATA_W] & {DATA_W{grant[i]}});
      if (grant[i]) begin
        win_idx = PTR_W'(i);
      end
    end

    rr_ptr_d = rr_ptr_q;
    tag_d    = tag_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    ack_d    = '0;
    if (any_grant) begin
      valid_d  = 1'b1;
      tag_d    = mux_tag;
      data_d   = mux_data;
      ack_d    = grant;
      rr_ptr_d = PTR_W'(rr_next(int'(win_idx), NUM_SRC));
    end
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      rr_ptr_q <= '0;
      ack_q    <= '0;
      valid_q  <= 1'b0;
      tag_q    <= '0;
      data_q   <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      ack_q    <= ack_d;
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      data_q   <= data_d;
    end
  end

  assign resultAC = ack_q;
  assign cdbValid = valid_q;
  assign cdbTag   = tag_q;
  assign cdbData  = data_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: rotating-search reference model checked every cycle, plus
// directed scenarios with literal expectations.
module tb_cdb_arbiter;

  localparam int NS = 4;
  localparam int TW = 4;
  localparam int DW = 32;

  logic              clk = 1'b0;
  logic              nRST = 1'b0;
  logic [NS-1:0]     reqValid = '0;
  logic [NS*TW-1:0]  reqTag = '0;
  logic [NS*DW-1:0]  reqData = '0;
  logic [NS-1:0]     resultAC;
  logic              cdbValid;
  logic [TW-1:0]     cdbTag;
  logic [DW-1:0]     cdbData;

  int errors = 0;
  int checks = 0;

  int            m_ptr = 0;
  logic [NS-1:0] m_ack = '0;
  logic          m_valid = 1'b0;
  logic [TW-1:0] m_tag = '0;
  logic [DW-1:0] m_data = '0;

  int grant_q[$];
  int pres_tag[NS];
  int tag_ctr = 0;

  cdb_arbiter #(.NUM_SRC(NS), .TAG_W(TW), .DATA_W(DW)) dut (
    .clk      (clk),
    .nRST     (nRST),
    .reqValid (reqValid),
    .reqTag   (reqTag),
    .reqData  (reqData),
    .resultAC (resultAC),
    .cdbValid (cdbValid),
    .cdbTag   (cdbTag),
    .cdbData  (cdbData)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_src(input int i, input logic v, input int t, input logic [DW-1:0] d);
    reqValid[i]          = v;
    reqTag[i*TW +: TW]   = TW'(t);
    reqData[i*DW +: DW]  = d;
    pres_tag[i]          = t;
  endtask

  function automatic int onehot_idx(input logic [NS-1:0] v);
    for (int i = 0; i < NS; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Reference: scan sources starting at the pointer; anyone acked last cycle sits out.
  always @(posedge clk or negedge nRST) begin
    int w;
    if (!nRST) begin
      m_ptr = 0; m_ack = '0; m_valid = 1'b0; m_tag = '0; m_data = '0;
    end else begin
      w = -1;
      for (int k = 0; k < NS; k++) begin
        int s;
        s = (m_ptr + k) % NS;
        if (w < 0 && reqValid[s] && !m_ack[s]) w = s;
      end
      m_ack = '0;
      if (w >= 0) begin
        m_valid  = 1'b1;
        m_tag    = reqTag[w*TW +: TW];
        m_data   = reqData[w*DW +: DW];
        m_ack[w] = 1'b1;
        m_ptr    = (w + 1) % NS;
      end else begin
        m_valid = 1'b0;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (nRST) begin
      chk("model_valid", 64'(cdbValid), 64'(m_valid));
      chk("model_ack", 64'(resultAC), 64'(m_ack));
      if (m_valid) begin
        chk("model_tag", 64'(cdbTag), 64'(m_tag));
        chk("model_data", 64'(cdbData), 64'(m_data));
      end
      if (resultAC != '0) begin
        grant_q.push_back(onehot_idx(resultAC));
        $display("grant src=%0d tag=%0d data=%08h", onehot_idx(resultAC), cdbTag, cdbData);
      end
    end
  end

  initial begin
    int cover_mask;
    int idx;

    // Reset, then idle with no requests.
    repeat (2) @(negedge clk);
    chk("reset_ack", 64'(resultAC), 64'h0);
    chk("reset_valid", 64'(cdbValid), 64'h0);
    nRST = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      chk("idle_ack", 64'(resultAC), 64'h0);
      chk("idle_valid", 64'(cdbValid), 64'h0);
      chk("idle_tag", 64'(cdbTag), 64'h0);
      chk("idle_data", 64'(cdbData), 64'h0);
    end

    // Single source 2.
    @(negedge clk); set_src(2, 1'b1, 5, 32'h0000_1234);
    @(posedge clk); #1;
    chk("single_valid", 64'(cdbValid), 64'h1);
    chk("single_tag", 64'(cdbTag), 64'h5);
    chk("single_data", 64'(cdbData), 64'h1234);
    chk("single_ack", 64'(resultAC), 64'b0100);
    @(negedge clk); set_src(2, 1'b0, 0, '0);
    @(posedge clk); #1;
    chk("single_drop_valid", 64'(cdbValid), 64'h0);

    // Source 1 holds its request through the ack with a fresh result.
    grant_q.delete();
    @(negedge clk); set_src(1, 1'b1, 6, 32'h0000_AAAA);
    @(posedge clk); #1;
    chk("hold_first_ack", 64'(resultAC), 64'b0010);
    chk("hold_first_data", 64'(cdbData), 64'hAAAA);
    @(negedge clk); set_src(1, 1'b1, 7, 32'h0000_BEEF);
    @(posedge clk); #1;
    chk("hold_masked_valid", 64'(cdbValid), 64'h0);
    chk("hold_masked_ack", 64'(resultAC), 64'h0);
    @(posedge clk); #1;
    chk("hold_second_ack", 64'(resultAC), 64'b0010);
    chk("hold_second_data", 64'(cdbData), 64'hBEEF);
    chk("hold_second_tag", 64'(cdbTag), 64'h7);
    @(negedge clk); set_src(1, 1'b0, 0, '0);
    @(posedge clk); #1;
    chk("hold_drop_valid", 64'(cdbValid), 64'h0);
    chk("hold_ack_count", 64'(grant_q.size()), 64'd2);

    // All four requesting from reset, each re-raising after its ack.
    @(negedge clk); nRST = 1'b0;
    for (int i = 0; i < NS; i++) begin
      tag_ctr = tag_ctr % 15 + 1;
      set_src(i, 1'b1, tag_ctr, 32'hC000_0000 + i);
    end
    repeat (2) @(negedge clk);
    grant_q.delete();
    nRST = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      idx = onehot_idx(resultAC);
      if (idx >= 0) chk("rr_cdb_tag", 64'(cdbTag), 64'(pres_tag[idx]));
      else chk("rr_ack_present", 64'(resultAC), 64'hF);
      @(negedge clk);
      for (int i = 0; i < NS; i++) begin
        if (resultAC[i]) begin
          tag_ctr = tag_ctr % 15 + 1;
          set_src(i, 1'b1, tag_ctr, 32'hD000_0000 + (c << 4) + i);
        end
      end
    end
    reqValid = '0;
    chk("rr_grant_count", 64'(grant_q.size()), 64'd12);
    if (grant_q.size() >= 12) begin
      for (int k = 0; k < 12; k++) chk("rr_order", 64'(grant_q[k]), 64'(k % NS));
      for (int k = 0; k + NS <= 12; k++) begin
        cover_mask = 0;
        for (int j = 0; j < NS; j++) cover_mask |= (1 << grant_q[k+j]);
        chk("rr_fair_window", 64'(cover_mask), 64'hF);
      end
    end

    // Wrap-around from pointer 3.
    @(negedge clk); nRST = 1'b0;
    @(negedge clk); nRST = 1'b1;
    grant_q.delete();
    @(negedge clk); set_src(2, 1'b1, 3, 32'h22);
    @(negedge clk);
    set_src(2, 1'b0, 0, '0);
    set_src(0, 1'b1, 1, 32'h00);
    set_src(3, 1'b1, 4, 32'h33);
    @(negedge clk); set_src(3, 1'b0, 0, '0);
    @(negedge clk); set_src(0, 1'b0, 0, '0);
    chk("wrap_count", 64'(grant_q.size()), 64'd3);
    if (grant_q.size() == 3) begin
      chk("wrap_g0", 64'(grant_q[0]), 64'd2);
      chk("wrap_g1", 64'(grant_q[1]), 64'd3);
      chk("wrap_g2", 64'(grant_q[2]), 64'd0);
    end
    @(negedge clk);
    set_src(0, 1'b1, 2, 32'h0A);
    set_src(1, 1'b1, 9, 32'h1B);
    @(posedge clk); #1;
    chk("wrap_ptr1_ack", 64'(resultAC), 64'b0010);
    chk("wrap_ptr1_valid", 64'(cdbValid), 64'h1);

    // Reset mid-broadcast, outputs clear without a clock edge.
    #2 nRST = 1'b0;
    #1;
    chk("async_ack", 64'(resultAC), 64'h0);
    chk("async_valid", 64'(cdbValid), 64'h0);
    chk("async_tag", 64'(cdbTag), 64'h0);
    chk("async_data", 64'(cdbData), 64'h0);
    set_src(0, 1'b0, 0, '0);
    set_src(2, 1'b1, 8, 32'h2C);
    @(negedge clk); nRST = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_ack", 64'(resultAC), 64'b0010);
    chk("post_reset_tag", 64'(cdbTag), 64'h9);
    @(negedge clk); reqValid = '0;
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
